// File: rtl/nbit_demux_reg_pkg.sv
// Shared definitions for the registered n-bit demux: FSM state encodings.
package nbit_demux_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nbit_demux_reg_decoder.sv
// Index-to-one-hot write-enable decoder shared by the random-access and serial paths.
module nbit_decoder #(
    parameter int SELECT_WIDTH = 3
) (
    input  logic [SELECT_WIDTH-1:0]    index,
    input  logic                       enable,
    output logic [2**SELECT_WIDTH-1:0] onehot
);

    always_comb begin
        onehot        = '0;
        onehot[index] = enable;
    end

endmodule

// File: rtl/nbit_demux_reg.sv
// Registered 1-to-2**SELECT_WIDTH demux with random-access writes and a serial LSB-first fill.
module nbit_demux_reg
    import nbit_demux_reg_pkg::*;
#(
    parameter int SELECT_WIDTH = 3
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       DemuxIn,
    input  logic [SELECT_WIDTH-1:0]    DemuxSel,
    input  logic                       DemuxWr,
    input  logic                       DemuxStart,
    input  logic                       DemuxValid,
    input  logic                       DemuxClr,
    output logic [2**SELECT_WIDTH-1:0] DemuxOut,
    output logic                       DemuxBusy,
    output logic                       DemuxDone
);

    localparam int WIDTH = 2**SELECT_WIDTH;
    localparam logic [SELECT_WIDTH-1:0] LAST_INDEX = SELECT_WIDTH'(WIDTH - 1);

    state_t                  state;
    logic [SELECT_WIDTH-1:0] count;
    logic [SELECT_WIDTH-1:0] wr_index;
    logic [WIDTH-1:0]        wr_onehot;
    logic                    wr_enable;

    // The serial fill borrows the same decoder, steered by the fill counter.
    assign wr_index  = (state == FILL) ? count : DemuxSel;
    assign wr_enable = ((state == IDLE) && DemuxWr) || ((state == FILL) && DemuxValid);

    nbit_decoder #(
        .SELECT_WIDTH(SELECT_WIDTH)
    ) u_decoder (
        .index  (wr_index),
        .enable (wr_enable),
        .onehot (wr_onehot)
    );

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            count     <= '0;
            DemuxOut  <= '0;
            DemuxBusy <= 1'b0;
            DemuxDone <= 1'b0;
        end else if (DemuxClr) begin
            state     <= IDLE;
            count     <= '0;
            DemuxOut  <= '0;
            DemuxBusy <= 1'b0;
            DemuxDone <= 1'b0;
        end else begin
            if (wr_enable) begin
                DemuxOut <= (DemuxOut & ~wr_onehot) | (wr_onehot & {WIDTH{DemuxIn}});
            end
            // Busy and Done are loaded with the decode of the next state so they stay registered.
            case (state)
                IDLE: begin
                    DemuxDone <= 1'b0;
                    if (DemuxStart) begin
                        count     <= '0;
                        state     <= FILL;
                        DemuxBusy <= 1'b1;
                    end
                end
                FILL: begin
                    if (DemuxValid) begin
                        count <= count + 1'b1;
                        if (count == LAST_INDEX) begin
                            state     <= DONE;
                            DemuxBusy <= 1'b0;
                            DemuxDone <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    DemuxDone <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    DemuxBusy <= 1'b0;
                    DemuxDone <= 1'b0;
                end
            endcase
        end
    end

endmodule
